// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
//   Multi-cycle control FSM for the RV32I core.
//   Sequences the states FETCH -> DECODE -> EXEC -> (MEM) -> (WB) around the
//   instruction decoder. It drives the IR/PC load strobes, the register-file
//   write enable, the ALU operand muxes and the data-memory requests.
//
//   Build option: MEM_TIMEOUT_EN
//     When this macro is defined, a wait counter bounds the FETCH and MEM waits.
//     The FSM traps with timeout=1 when the counter reaches TIMEOUT_CYCLES.
//     When the macro is undefined, waits are unbounded and timeout is tied to 0.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   opcode, funct3    decoder fields, sampled only in DECODE
//   br_taken          ALU compare result, used in EXEC of a branch
//   imem_req/ready    instruction fetch handshake
//   dmem_req/we/ready data access handshake (we=1 store)
//   ir_load, pc_write instruction register / PC load strobes
//   pc_sel            00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//   reg_write         register-file write enable
//   alu_a_pc, alu_b_imm ALU operand selects
//   wb_sel            00 ALU, 01 load data, 10 PC+4, 11 imm
//   op_f3             funct3 latched in DECODE
//   retire            one pulse per completed instruction
//   illegal, timeout  sticky trap causes
//   state             IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | instruction request outstanding
// DECODE | latch opcode class and funct3
// EXEC   | ALU operation, branches resolve here
// MEM    | data access outstanding
// WB     | register write-back and PC update
// TRAP   | illegal opcode or memory timeout, left only by reset
module riscv_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       reg_write,
  output logic       alu_a_pc,
  output logic       alu_b_imm,
  output logic [1:0] wb_sel,
  output logic [2:0] op_f3,
  output logic       retire,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  if (2**CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  state_t     state_q;
  cls_t       cls_q;
  cls_t       cls_dec;
  logic [2:0] f3_q;

  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    case (op)
      7'b0110011: c = C_R;
      7'b0010011: c = C_I;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BR;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      default:    c = C_NONE;
    endcase
    return c;
  endfunction

  assign cls_dec = classify(opcode);

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;
  logic             waiting;

  // Any cycle that is not a stalled wait clears the counter, so every entry to
  // FETCH or MEM starts the count from zero.
  assign waiting = ((state_q == S_FETCH) && !imem_ready) ||
                   ((state_q == S_MEM)   && !dmem_ready);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      f3_q    <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      cnt_q <= waiting ? cnt_q + 1'b1 : '0;
`endif
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) state_q <= S_DECODE;
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == TMO_LIM) begin
            state_q <= S_TRAP;
            tmo_q   <= 1'b1;
          end
`endif
        end
        S_DECODE: begin
          cls_q   <= cls_dec;
          f3_q    <= funct3;
          state_q <= (cls_dec == C_NONE) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          if (cls_q == C_BR)                             state_q <= S_FETCH;
          else if (cls_q == C_LOAD || cls_q == C_STORE)  state_q <= S_MEM;
          else                                           state_q <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) state_q <= (cls_q == C_STORE) ? S_FETCH : S_WB;
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == TMO_LIM) begin
            state_q <= S_TRAP;
            tmo_q   <= 1'b1;
          end
`endif
        end
        S_WB:     state_q <= S_FETCH;
        S_TRAP:   state_q <= S_TRAP;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 2'b00;
    reg_write = 1'b0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    wb_sel    = 2'b00;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_EXEC: begin
        case (cls_q)
          C_I, C_LOAD, C_STORE, C_JALR: alu_b_imm = 1'b1;
          C_AUIPC: begin
            alu_a_pc  = 1'b1;
            alu_b_imm = 1'b1;
          end
          C_BR: begin
            pc_write = 1'b1;
            pc_sel   = br_taken ? 2'b01 : 2'b00;
            retire   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        // A store completes in the ready cycle; a load still needs WB.
        if (dmem_ready && cls_q == C_STORE) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        case (cls_q)
          C_LOAD:       wb_sel = 2'b01;
          C_JAL:        begin wb_sel = 2'b10; pc_sel = 2'b01; end
          C_JALR:       begin wb_sel = 2'b10; pc_sel = 2'b10; end
          C_LUI:        wb_sel = 2'b11;
          default:      wb_sel = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  assign illegal = (state_q == S_TRAP) && !tmo_q;
  assign timeout = tmo_q;
`else
  assign illegal = (state_q == S_TRAP);
  assign timeout = 1'b0;
`endif

  assign op_f3 = f3_q;
  assign state = state_q;

endmodule
